// File: rtl/mem_check_pkg.sv
// Purpose: shared types and constants for the data-memory write checker.
// Latency: n/a (types only).
// Backpressure: n/a; the checker only snoops and never stalls the core.
// Contents: chk_state_t FSM encoding, stray-counter width and saturation value.
package mem_check_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    PASS  = 2'd2,
    FAIL  = 2'd3
  } chk_state_t;

  localparam int                  STRAY_W   = 8;
  localparam logic [STRAY_W-1:0]  STRAY_MAX = '1;

endpackage

// File: rtl/exp_table.sv
// Purpose: register file of expected stores (address/data pairs).
// Latency: write lands on the next rising edge; read is combinational.
// Backpressure: none; a write is accepted every cycle we_i is high.
// Ports: clk; we_i/wr_idx_i/wr_addr_i/wr_data_i write port;
//        rd_idx_i selects the entry driven on rd_addr_o/rd_data_o.
module exp_table #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int IDX_W  = 3
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [DATA_W-1:0] rd_data_o
);

  // No reset: contents are reloaded by software before each check and are
  // deliberately kept across a checker reset so a check can be re-run.
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      addr_q[wr_idx_i] <= wr_addr_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_addr_o = addr_q[rd_idx_i];
  assign rd_data_o = data_q[rd_idx_i];

endmodule

// File: rtl/mem_write_checker.sv
// Purpose: snoops the core's store port and checks it against an ordered table of expected stores.
// Latency: verdict (pass/fail/timeout) is registered, visible the cycle after the deciding write.
// Backpressure: none; purely passive monitor, every MemWrite cycle is evaluated.
// Ports: clk/reset; cfg_* table load and count; start arms; MemWrite/DataAdr/WriteData snooped;
//        busy/done/pass/fail/timeout status; exp_idx/match_count/stray_count progress; fail_addr/fail_data capture.
module mem_write_checker
  import mem_check_pkg::*;
#(
  parameter int  ADDR_W      = 32,
  parameter int  DATA_W      = 32,
  parameter int  DEPTH       = 8,
  parameter int  TIMEOUT_CYC = 1000,
  parameter int  STRICT      = 0,
  localparam int IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [ADDR_W-1:0]  cfg_addr,
  input  logic [DATA_W-1:0]  cfg_data,
  input  logic [CNT_W-1:0]   cfg_count,
  input  logic               start,
  input  logic               MemWrite,
  input  logic [ADDR_W-1:0]  DataAdr,
  input  logic [DATA_W-1:0]  WriteData,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               fail,
  output logic               timeout,
  output logic [CNT_W-1:0]   exp_idx,
  output logic [CNT_W-1:0]   match_count,
  output logic [STRAY_W-1:0] stray_count,
  output logic [ADDR_W-1:0]  fail_addr,
  output logic [DATA_W-1:0]  fail_data
);

  localparam int                 TMR_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0]   TMR_ONE   = TMR_W'(1);
  localparam logic [TMR_W-1:0]   TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(DEPTH);
  localparam logic [STRAY_W-1:0] STRAY_ONE = STRAY_W'(1);

  chk_state_t         state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   exp_idx_q, exp_idx_d;
  logic [CNT_W-1:0]   match_q, match_d;
  logic [STRAY_W-1:0] stray_q, stray_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               timeout_q, timeout_d;
  logic [ADDR_W-1:0]  fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0]  fail_data_q, fail_data_d;

  logic [ADDR_W-1:0]  tbl_addr;
  logic [DATA_W-1:0]  tbl_data;
  logic [CNT_W-1:0]   start_count;
  logic               addr_eq, data_eq;
  logic               wr_match, wr_fail, wr_stray, last_entry, tmo_hit;

  exp_table #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_exp_table (
    .clk       (clk),
    .we_i      (cfg_we && (state_q == IDLE)),
    .wr_idx_i  (cfg_idx),
    .wr_addr_i (cfg_addr),
    .wr_data_i (cfg_data),
    .rd_idx_i  (exp_idx_q[IDX_W-1:0]),
    .rd_addr_o (tbl_addr),
    .rd_data_o (tbl_data)
  );

  // A count larger than the table would index past its end; clamp it.
  assign start_count = (cfg_count > CNT_MAX) ? CNT_MAX : cfg_count;

  assign addr_eq    = (DataAdr == tbl_addr);
  assign data_eq    = (WriteData == tbl_data);
  assign wr_match   = MemWrite && addr_eq && data_eq;
  assign wr_fail    = MemWrite && (addr_eq ? !data_eq : (STRICT != 0));
  assign wr_stray   = MemWrite && !addr_eq && (STRICT == 0);
  assign last_entry = ((exp_idx_q + CNT_ONE) == count_q);
  // Expires on the cycle the timer would reach TIMEOUT_CYC.
  assign tmo_hit    = (timer_q == TMR_LAST);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A match beats both a compare failure and the timer expiring.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARMED: begin
        if (wr_match) begin
          if (last_entry) state_d = PASS;
        end else if (wr_fail || tmo_hit) begin
          state_d = FAIL;
        end
      end
      default: begin
        if (start) state_d = (start_count == '0) ? PASS : ARMED;
      end
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    pass = 1'b0;
    fail = 1'b0;
    case (state_q)
      ARMED:   busy = 1'b1;
      PASS:    begin done = 1'b1; pass = 1'b1; end
      FAIL:    begin done = 1'b1; fail = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    count_d     = count_q;
    exp_idx_d   = exp_idx_q;
    match_d     = match_q;
    stray_d     = stray_q;
    timer_d     = timer_q;
    timeout_d   = timeout_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    if (state_q == ARMED) begin
      if (wr_match) begin
        match_d   = match_q + CNT_ONE;
        exp_idx_d = exp_idx_q + CNT_ONE;
        timer_d   = '0;
      end else if (wr_fail) begin
        fail_addr_d = DataAdr;
        fail_data_d = WriteData;
      end else begin
        timer_d = timer_q + TMR_ONE;
        if (wr_stray && (stray_q != STRAY_MAX)) stray_d = stray_q + STRAY_ONE;
        if (tmo_hit) timeout_d = 1'b1;
      end
    end else if (start) begin
      count_d     = start_count;
      exp_idx_d   = '0;
      match_d     = '0;
      stray_d     = '0;
      timer_d     = '0;
      timeout_d   = 1'b0;
      fail_addr_d = '0;
      fail_data_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= '0;
      exp_idx_q   <= '0;
      match_q     <= '0;
      stray_q     <= '0;
      timer_q     <= '0;
      timeout_q   <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else begin
      count_q     <= count_d;
      exp_idx_q   <= exp_idx_d;
      match_q     <= match_d;
      stray_q     <= stray_d;
      timer_q     <= timer_d;
      timeout_q   <= timeout_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
    end
  end

  assign timeout     = timeout_q;
  assign exp_idx     = exp_idx_q;
  assign match_count = match_q;
  assign stray_count = stray_q;
  assign fail_addr   = fail_addr_q;
  assign fail_data   = fail_data_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Purpose: self-checking bench; a lax (STRICT=0) and a strict (STRICT=1) checker share one stimulus.
// Latency: verdict edge is predicted by an event-level model of expected stores.
// Backpressure: n/a.
module tb_mem_write_checker;
  localparam int DEPTH = 8;
  localparam int TMO   = 20;
  localparam int NE    = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_we;
  logic [2:0]  cfg_idx;
  logic [31:0] cfg_addr, cfg_data;
  logic [3:0]  cfg_count;
  logic        start, MemWrite;
  logic [31:0] DataAdr, WriteData;

  logic        busy_w[2], done_w[2], pass_w[2], fail_w[2], tmo_w[2];
  logic [3:0]  idx_w[2], mc_w[2];
  logic [7:0]  sc_w[2];
  logic [31:0] fa_w[2], fd_w[2];

  always #5 clk = ~clk;

  mem_write_checker #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .TIMEOUT_CYC(TMO), .STRICT(0)) u_lax (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_count(cfg_count), .start(start), .MemWrite(MemWrite),
    .DataAdr(DataAdr), .WriteData(WriteData), .busy(busy_w[0]), .done(done_w[0]),
    .pass(pass_w[0]), .fail(fail_w[0]), .timeout(tmo_w[0]), .exp_idx(idx_w[0]),
    .match_count(mc_w[0]), .stray_count(sc_w[0]), .fail_addr(fa_w[0]), .fail_data(fd_w[0]));

  mem_write_checker #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .TIMEOUT_CYC(TMO), .STRICT(1)) u_strict (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_count(cfg_count), .start(start), .MemWrite(MemWrite),
    .DataAdr(DataAdr), .WriteData(WriteData), .busy(busy_w[1]), .done(done_w[1]),
    .pass(pass_w[1]), .fail(fail_w[1]), .timeout(tmo_w[1]), .exp_idx(idx_w[1]),
    .match_count(mc_w[1]), .stray_count(sc_w[1]), .fail_addr(fa_w[1]), .fail_data(fd_w[1]));

  typedef struct {
    bit          pass_v;
    bit          tmo;
    logic [31:0] fa, fd;
    int          idx, mc, sc, edge_v;
  } res_t;

  typedef struct {
    bit          seen, busy_ok, pass_v, fail_v, tmo;
    logic [31:0] fa, fd;
    int          idx, mc, sc, edge_v;
  } obs_t;

  int total = 0;
  int bad   = 0;

  // Scenario: table, count, and per-edge stimulus (edge 0 samples start).
  logic [31:0] tbl_a[DEPTH], tbl_d[DEPTH];
  int          cnt;
  logic        wv[NE], cwv[NE];
  logic [31:0] wa[NE], wd[NE], cwa[NE], cwd[NE];
  logic [2:0]  cwi[NE];
  obs_t        ob[2];

  // Walks the write events in order; the deadline for the next match is
  // always (last match edge + TMO), and a write on the deadline edge still counts.
  function automatic res_t model(input bit strict);
    res_t r;
    int   last;
    r    = '{default: 0};
    last = 0;
    if (cnt == 0) begin
      r.pass_v = 1'b1;
      return r;
    end
    for (int e = 1; e < NE; e++) begin
      if (e > last + TMO) begin
        r.tmo = 1'b1; r.edge_v = last + TMO;
        return r;
      end
      if (wv[e]) begin
        if (wa[e] == tbl_a[r.idx]) begin
          if (wd[e] == tbl_d[r.idx]) begin
            r.idx++; r.mc++; last = e;
            if (r.idx == cnt) begin
              r.pass_v = 1'b1; r.edge_v = e;
              return r;
            end
          end else begin
            r.fa = wa[e]; r.fd = wd[e]; r.edge_v = e;
            return r;
          end
        end else if (strict) begin
          r.fa = wa[e]; r.fd = wd[e]; r.edge_v = e;
          return r;
        end else if (r.sc < 255) begin
          r.sc++;
        end
      end
    end
    r.tmo = 1'b1; r.edge_v = last + TMO;
    return r;
  endfunction

  task automatic new_scn();
    for (int e = 0; e < NE; e++) begin
      wv[e] = 1'b0; wa[e] = '0; wd[e] = '0;
      cwv[e] = 1'b0; cwi[e] = '0; cwa[e] = '0; cwd[e] = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      tbl_a[i] = 32'h1000 + 32'(i); tbl_d[i] = '0;
    end
    tbl_a[0] = 32'd96;  tbl_d[0] = 32'd7;
    tbl_a[1] = 32'd100; tbl_d[1] = 32'd25;
    cnt = 2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; MemWrite = 1'b0; cfg_we = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic load_tbl();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      cfg_we = 1'b1; cfg_idx = 3'(i); cfg_addr = tbl_a[i]; cfg_data = tbl_d[i];
    end
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Drives start then the per-edge schedule; records the first done edge and
  // the outputs at that edge for each checker. abort_at >= 0 stops early.
  task automatic run_scn(input int abort_at);
    for (int k = 0; k < 2; k++) begin
      ob[k] = '{default: 0};
      ob[k].busy_ok = 1'b1;
      ob[k].edge_v  = -1;
    end
    @(negedge clk);
    start = 1'b1; cfg_count = 4'(cnt);
    @(negedge clk);
    start = 1'b0;
    for (int e = 0; e < NE; e++) begin
      if (e == abort_at) break;
      for (int k = 0; k < 2; k++) begin
        if (!ob[k].seen) begin
          if (done_w[k]) begin
            ob[k].seen = 1'b1; ob[k].edge_v = e;
            ob[k].pass_v = pass_w[k]; ob[k].fail_v = fail_w[k]; ob[k].tmo = tmo_w[k];
            ob[k].fa = fa_w[k]; ob[k].fd = fd_w[k];
            ob[k].idx = int'(idx_w[k]); ob[k].mc = int'(mc_w[k]); ob[k].sc = int'(sc_w[k]);
          end else if (!busy_w[k]) begin
            ob[k].busy_ok = 1'b0;
          end
        end
      end
      if (ob[0].seen && ob[1].seen) break;
      if (e < NE - 1) begin
        MemWrite = wv[e+1]; DataAdr = wa[e+1]; WriteData = wd[e+1];
        cfg_we = cwv[e+1]; cfg_idx = cwi[e+1]; cfg_addr = cwa[e+1]; cfg_data = cwd[e+1];
        @(negedge clk);
      end
    end
    MemWrite = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({busy_w[k], done_w[k], pass_w[k], fail_w[k], tmo_w[k]} !== 5'b0) begin
        bad++; $display("FAIL reset_flags inst%0d got %b want 00000", k,
                        {busy_w[k], done_w[k], pass_w[k], fail_w[k], tmo_w[k]});
      end
      total++;
      if ({idx_w[k], mc_w[k], sc_w[k]} !== 16'h0) begin
        bad++; $display("FAIL reset_counts inst%0d got idx=%0d mc=%0d sc=%0d want 0", k, idx_w[k], mc_w[k], sc_w[k]);
      end
      total++;
      if ({fa_w[k], fd_w[k]} !== 64'h0) begin
        bad++; $display("FAIL reset_capture inst%0d got %h/%h want 0", k, fa_w[k], fd_w[k]);
      end
    end
  endtask

  task automatic test_pass();
    res_t m;
    new_scn();
    wv[2] = 1; wa[2] = 96;  wd[2] = 7;
    wv[4] = 1; wa[4] = 100; wd[4] = 25;
    do_reset(); load_tbl(); run_scn(-1);
    for (int k = 0; k < 2; k++) begin
      m = model(k == 1);
      total++;
      if (ob[k].edge_v !== m.edge_v || ob[k].pass_v !== m.pass_v) begin
        bad++; $display("FAIL pass_verdict inst%0d got edge=%0d pass=%0d want edge=%0d pass=%0d",
                        k, ob[k].edge_v, ob[k].pass_v, m.edge_v, m.pass_v);
      end
      total++;
      if (ob[k].mc !== m.mc || ob[k].sc !== m.sc) begin
        bad++; $display("FAIL pass_counts inst%0d got mc=%0d sc=%0d want mc=%0d sc=%0d", k, ob[k].mc, ob[k].sc, m.mc, m.sc);
      end
    end
  endtask

  task automatic test_mismatch();
    res_t m;
    new_scn();
    wv[1] = 1; wa[1] = 96;  wd[1] = 7;
    wv[3] = 1; wa[3] = 100; wd[3] = 24;
    do_reset(); load_tbl(); run_scn(-1);
    for (int k = 0; k < 2; k++) begin
      m = model(k == 1);
      total++;
      if (ob[k].edge_v !== m.edge_v || ob[k].fail_v !== !m.pass_v || ob[k].tmo !== m.tmo) begin
        bad++; $display("FAIL mismatch_verdict inst%0d got edge=%0d fail=%0d tmo=%0d want edge=%0d fail=%0d tmo=%0d",
                        k, ob[k].edge_v, ob[k].fail_v, ob[k].tmo, m.edge_v, !m.pass_v, m.tmo);
      end
      total++;
      if (ob[k].fa !== m.fa || ob[k].fd !== m.fd || ob[k].idx !== m.idx) begin
        bad++; $display("FAIL mismatch_capture inst%0d got %0d/%0d idx=%0d want %0d/%0d idx=%0d",
                        k, ob[k].fa, ob[k].fd, ob[k].idx, m.fa, m.fd, m.idx);
      end
    end
  endtask

  task automatic test_stray();
    res_t m;
    new_scn();
    wv[1] = 1; wa[1] = 96;  wd[1] = 7;
    wv[2] = 1; wa[2] = 80;  wd[2] = 3;
    wv[3] = 1; wa[3] = 100; wd[3] = 25;
    do_reset(); load_tbl(); run_scn(-1);
    for (int k = 0; k < 2; k++) begin
      m = model(k == 1);
      total++;
      if (ob[k].edge_v !== m.edge_v || ob[k].pass_v !== m.pass_v || ob[k].fail_v !== !m.pass_v) begin
        bad++; $display("FAIL stray_verdict inst%0d got edge=%0d pass=%0d want edge=%0d pass=%0d",
                        k, ob[k].edge_v, ob[k].pass_v, m.edge_v, m.pass_v);
      end
      total++;
      if (ob[k].sc !== m.sc || ob[k].fa !== m.fa || ob[k].fd !== m.fd) begin
        bad++; $display("FAIL stray_detail inst%0d got sc=%0d cap=%0d/%0d want sc=%0d cap=%0d/%0d",
                        k, ob[k].sc, ob[k].fa, ob[k].fd, m.sc, m.fa, m.fd);
      end
    end
  endtask

  task automatic test_timeout();
    res_t m;
    new_scn();
    do_reset(); load_tbl(); run_scn(-1);
    for (int k = 0; k < 2; k++) begin
      m = model(k == 1);
      total++;
      if (ob[k].edge_v !== m.edge_v || ob[k].tmo !== m.tmo || ob[k].fail_v !== !m.pass_v || !ob[k].busy_ok) begin
        bad++; $display("FAIL timeout_verdict inst%0d got edge=%0d tmo=%0d fail=%0d busy_ok=%0d want edge=%0d tmo=%0d fail=1",
                        k, ob[k].edge_v, ob[k].tmo, ob[k].fail_v, ob[k].busy_ok, m.edge_v, m.tmo);
      end
      total++;
      if (ob[k].fa !== 32'h0 || ob[k].fd !== 32'h0) begin
        bad++; $display("FAIL timeout_capture inst%0d got %h/%h want 0/0", k, ob[k].fa, ob[k].fd);
      end
    end
  endtask

  task automatic test_count_zero();
    res_t m;
    new_scn();
    cnt = 0;
    do_reset(); load_tbl(); run_scn(-1);
    for (int k = 0; k < 2; k++) begin
      m = model(k == 1);
      total++;
      if (ob[k].edge_v !== m.edge_v || ob[k].pass_v !== m.pass_v || ob[k].mc !== m.mc) begin
        bad++; $display("FAIL count_zero inst%0d got edge=%0d pass=%0d mc=%0d want edge=%0d pass=%0d mc=%0d",
                        k, ob[k].edge_v, ob[k].pass_v, ob[k].mc, m.edge_v, m.pass_v, m.mc);
      end
    end
  endtask

  task automatic test_match_on_timeout();
    res_t m;
    new_scn();
    wv[TMO]   = 1; wa[TMO]   = 96;  wd[TMO]   = 7;
    wv[2*TMO] = 1; wa[2*TMO] = 100; wd[2*TMO] = 25;
    do_reset(); load_tbl(); run_scn(-1);
    for (int k = 0; k < 2; k++) begin
      m = model(k == 1);
      total++;
      if (ob[k].edge_v !== m.edge_v || ob[k].pass_v !== m.pass_v || ob[k].tmo !== m.tmo) begin
        bad++; $display("FAIL match_on_timeout inst%0d got edge=%0d pass=%0d tmo=%0d want edge=%0d pass=%0d tmo=%0d",
                        k, ob[k].edge_v, ob[k].pass_v, ob[k].tmo, m.edge_v, m.pass_v, m.tmo);
      end
    end
  endtask

  task automatic test_cfg_locked();
    res_t m;
    new_scn();
    cwv[1] = 1; cwi[1] = 3'd0; cwa[1] = 96;  cwd[1] = 99;
    cwv[2] = 1; cwi[2] = 3'd1; cwa[2] = 100; cwd[2] = 26;
    wv[3] = 1; wa[3] = 96;  wd[3] = 7;
    wv[4] = 1; wa[4] = 100; wd[4] = 25;
    do_reset(); load_tbl(); run_scn(-1);
    for (int k = 0; k < 2; k++) begin
      m = model(k == 1);
      total++;
      if (ob[k].edge_v !== m.edge_v || ob[k].pass_v !== m.pass_v || ob[k].mc !== m.mc) begin
        bad++; $display("FAIL cfg_locked inst%0d got edge=%0d pass=%0d mc=%0d want edge=%0d pass=%0d mc=%0d",
                        k, ob[k].edge_v, ob[k].pass_v, ob[k].mc, m.edge_v, m.pass_v, m.mc);
      end
    end
  endtask

  task automatic test_reset_mid();
    res_t m;
    new_scn();
    wv[2] = 1; wa[2] = 96;  wd[2] = 7;
    wv[7] = 1; wa[7] = 100; wd[7] = 25;
    do_reset(); load_tbl(); run_scn(5);
    do_reset();
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({busy_w[k], done_w[k], pass_w[k], fail_w[k], tmo_w[k]} !== 5'b0 ||
          idx_w[k] !== 4'd0 || mc_w[k] !== 4'd0 || sc_w[k] !== 8'd0) begin
        bad++; $display("FAIL reset_mid_clear inst%0d got busy=%0d done=%0d idx=%0d mc=%0d sc=%0d want all 0",
                        k, busy_w[k], done_w[k], idx_w[k], mc_w[k], sc_w[k]);
      end
    end
    run_scn(-1);
    for (int k = 0; k < 2; k++) begin
      m = model(k == 1);
      total++;
      if (ob[k].edge_v !== m.edge_v || ob[k].pass_v !== m.pass_v || ob[k].mc !== m.mc) begin
        bad++; $display("FAIL reset_mid_rerun inst%0d got edge=%0d pass=%0d mc=%0d want edge=%0d pass=%0d mc=%0d",
                        k, ob[k].edge_v, ob[k].pass_v, ob[k].mc, m.edge_v, m.pass_v, m.mc);
      end
    end
  endtask

  task automatic test_random();
    res_t m;
    int   e, gap;
    for (int it = 0; it < 25; it++) begin
      new_scn();
      for (int i = 0; i < DEPTH; i++) begin
        tbl_a[i] = 32'h100 + 32'(16 * i) + 32'(4 * $urandom_range(0, 3));
        tbl_d[i] = $urandom;
      end
      cnt = int'($urandom_range(1, DEPTH));
      e = 1;
      for (int i = 0; i < cnt; i++) begin
        gap = int'($urandom_range(0, 4));
        if ($urandom_range(0, 9) == 0) gap = TMO + 2;
        for (int g = 0; g < gap && e < NE; g++) begin
          if ($urandom_range(0, 2) == 0) begin
            wv[e] = 1'b1;
            wa[e] = ($urandom_range(0, 1) == 0) ? 32'h800 + 32'(4 * $urandom_range(0, 15))
                                                : tbl_a[$urandom_range(0, DEPTH - 1)];
            wd[e] = $urandom;
          end
          e++;
        end
        if (gap > TMO || e >= NE) break;
        wv[e] = 1'b1; wa[e] = tbl_a[i];
        wd[e] = ($urandom_range(0, 11) == 0) ? (tbl_d[i] ^ 32'h10) : tbl_d[i];
        e++;
      end
      do_reset(); load_tbl(); run_scn(-1);
      for (int k = 0; k < 2; k++) begin
        m = model(k == 1);
        total++;
        if (ob[k].edge_v !== m.edge_v || !ob[k].busy_ok) begin
          bad++; $display("FAIL rnd_edge it%0d inst%0d got edge=%0d busy_ok=%0d want edge=%0d", it, k, ob[k].edge_v, ob[k].busy_ok, m.edge_v);
        end
        total++;
        if (ob[k].pass_v !== m.pass_v || ob[k].fail_v !== !m.pass_v || ob[k].tmo !== m.tmo) begin
          bad++; $display("FAIL rnd_verdict it%0d inst%0d got pass=%0d fail=%0d tmo=%0d want pass=%0d tmo=%0d",
                          it, k, ob[k].pass_v, ob[k].fail_v, ob[k].tmo, m.pass_v, m.tmo);
        end
        total++;
        if (ob[k].idx !== m.idx || ob[k].mc !== m.mc || ob[k].sc !== m.sc) begin
          bad++; $display("FAIL rnd_counts it%0d inst%0d got idx=%0d mc=%0d sc=%0d want idx=%0d mc=%0d sc=%0d",
                          it, k, ob[k].idx, ob[k].mc, ob[k].sc, m.idx, m.mc, m.sc);
        end
        total++;
        if (ob[k].fa !== m.fa || ob[k].fd !== m.fd) begin
          bad++; $display("FAIL rnd_capture it%0d inst%0d got %h/%h want %h/%h", it, k, ob[k].fa, ob[k].fd, m.fa, m.fd);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0; cfg_data = '0; cfg_count = '0;
    start = 1'b0; MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
    test_reset();
    test_pass();
    test_mismatch();
    test_stray();
    test_timeout();
    test_count_zero();
    test_match_on_timeout();
    test_cfg_locked();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
